// File: rtl/refresh_sched_pkg.sv
// -----------------------------------------------------------------------------
// refresh_sched_pkg
// Shared definitions for the SDRAM refresh scheduler:
//   - rs_state_e   : scheduler FSM state encoding (IDLE / REQ / WAIT)
//   - MAX_PEND_DEF : default ceiling on postponed refreshes per rank
//   - pend_w()     : width of a pending counter able to hold 0..max_pend
//   - rank_w()     : width of a rank index (at least one bit)
//   - lowest_set() : index of the lowest set bit of an 8-bit vector
// -----------------------------------------------------------------------------
package refresh_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } rs_state_e;

  localparam int MAX_PEND_DEF = 8;

  function automatic int pend_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

  function automatic int rank_w(input int ranks);
    return (ranks > 1) ? $clog2(ranks) : 1;
  endfunction

  // RANKS never exceeds 8, so an 8-bit vector covers every rank set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ref_rank_cnt.sv
// -----------------------------------------------------------------------------
// ref_rank_cnt
// Per-rank refresh bookkeeping: a tREFI interval counter and a saturating
// count of refreshes owed to the rank.
// Ports:
//   mclk, s_resetn : clock, synchronous active-low reset
//   run            : counting enabled (init done and interval non-zero)
//   cfg_trefi      : interval length in mclk cycles
//   done           : the refresh issued for this rank has completed
//   pend           : refreshes currently owed
//   sat_tick       : an interval tick was dropped because pend was full
// -----------------------------------------------------------------------------
module ref_rank_cnt
  import refresh_sched_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int PW       = pend_w(MAX_PEND)
) (
  input  logic             mclk,
  input  logic             s_resetn,
  input  logic             run,
  input  logic [CNT_W-1:0] cfg_trefi,
  input  logic             done,
  output logic [PW-1:0]    pend,
  output logic             sat_tick
);

  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic             tick;

  // Interval counter. The >= compare lets a shrinking cfg_trefi wrap at once
  // instead of running the counter all the way round.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q >= cfg_trefi - 1'b1) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pending count: a tick and a completion in the same cycle cancel out.
  // While counting is disabled the owed count is frozen as well.
  always_comb begin
    pend_d   = pend_q;
    sat_tick = 1'b0;
    if (run) begin
      if (tick && !done) begin
        if (pend_q == PEND_MAX) sat_tick = 1'b1;
        else                    pend_d   = pend_q + 1'b1;
      end else if (done && !tick && (pend_q != '0)) begin
        pend_d = pend_q - 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!s_resetn) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/refresh_sched.sv
// -----------------------------------------------------------------------------
// refresh_sched
// Multi-rank SDRAM refresh scheduler with host-request gating.
// Each rank accumulates owed refreshes every cfg_trefi cycles; the scheduler
// issues them opportunistically while the host is idle, or forcibly once a
// rank owes cfg_urgent or more, in which case host traffic is held off.
// Ports:
//   mclk, s_resetn       : clock, synchronous active-low reset
//   init_done            : SDRAM initialisation complete
//   cfg_trefi            : refresh interval (0 disables refresh)
//   cfg_urgent           : owed-refresh threshold that forces refresh (0 = never)
//   host_req, host_wr_n  : host request and direction (0 = write, 1 = read)
//   ref_ack, trfc_done   : sequencer handshake for the issued refresh
//   ref_req, ref_rank    : refresh request and its target rank
//   ref_urgent           : some rank is at/above the forcing threshold
//   wen, ren             : qualified host write / read enables
//   pend_ovf             : sticky, an interval tick was lost at MAX_PEND
// -----------------------------------------------------------------------------
module refresh_sched
  import refresh_sched_pkg::*;
#(
  parameter  int RANKS    = 2,
  parameter  int CNT_W    = 12,
  parameter  int MAX_PEND = MAX_PEND_DEF,
  localparam int PW       = pend_w(MAX_PEND),
  localparam int RW       = rank_w(RANKS)
) (
  input  logic             mclk,
  input  logic             s_resetn,
  input  logic             init_done,
  input  logic [CNT_W-1:0] cfg_trefi,
  input  logic [PW-1:0]    cfg_urgent,
  input  logic             host_req,
  input  logic             host_wr_n,
  input  logic             ref_ack,
  input  logic             trfc_done,
  output logic             ref_req,
  output logic [RW-1:0]    ref_rank,
  output logic             ref_urgent,
  output logic             wen,
  output logic             ren,
  output logic             pend_ovf
);

  rs_state_e        state_q, state_d;
  logic             ref_req_q, ref_req_d;
  logic [RW-1:0]    ref_rank_q, ref_rank_d;
  logic [RW-1:0]    ptr_q, ptr_d;
  logic             ref_urgent_q, ref_urgent_d;
  logic             pend_ovf_q, pend_ovf_d;
  logic             wrl_q, wrl_d;
  logic             host_req_q, host_req_d;

  logic             run;
  logic [RANKS-1:0] done_vec, sat_vec, forced_vec, opp_vec;
  logic [RANKS-1:0] hi_mask, cand;
  logic [PW-1:0]    pend_arr [RANKS];
  logic [RW-1:0]    pick_rank;
  logic             any_elig;
  logic             wrl, blocked, host_ok;

  assign run = init_done && (cfg_trefi != '0);

  // ---------------------------------------------------------------------------
  // Per-rank counters and eligibility
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < RANKS; gi++) begin : g_rank
      // Completion only counts against the rank actually being refreshed.
      assign done_vec[gi] = trfc_done && (state_q == ST_WAIT) &&
                            (ref_rank_q == RW'(gi));

      ref_rank_cnt #(
        .CNT_W    (CNT_W),
        .MAX_PEND (MAX_PEND),
        .PW       (PW)
      ) u_cnt (
        .mclk      (mclk),
        .s_resetn  (s_resetn),
        .run       (run),
        .cfg_trefi (cfg_trefi),
        .done      (done_vec[gi]),
        .pend      (pend_arr[gi]),
        .sat_tick  (sat_vec[gi])
      );

      assign forced_vec[gi] = (cfg_urgent != '0) && (pend_arr[gi] >= cfg_urgent);
      assign opp_vec[gi]    = (pend_arr[gi] != '0) && !host_req;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin pick: search ranks ptr..RANKS-1 first, then wrap to 0..ptr-1.
  // Forced candidates shadow opportunistic ones entirely.
  // ---------------------------------------------------------------------------
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < RANKS; i++) begin
      hi_mask[i] = (i >= int'(ptr_q));
    end
    if (|forced_vec) begin
      cand = (|(forced_vec & hi_mask)) ? (forced_vec & hi_mask) : forced_vec;
    end else begin
      cand = (|(opp_vec & hi_mask)) ? (opp_vec & hi_mask) : opp_vec;
    end
    any_elig  = |(forced_vec | opp_vec);
    pick_rank = RW'(lowest_set(8'(cand)));
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM next-state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ref_req_d  = ref_req_q;
    ref_rank_d = ref_rank_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_d    = ST_REQ;
          ref_req_d  = 1'b1;
          ref_rank_d = pick_rank;
        end
      end
      ST_REQ: begin
        if (ref_ack) begin
          state_d   = ST_WAIT;
          ref_req_d = 1'b0;
          ptr_d     = (ref_rank_q == RW'(RANKS - 1)) ? '0 : ref_rank_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (trfc_done) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        ref_req_d = 1'b0;
      end
    endcase
  end

  // Host direction: latch host_wr_n on the request's rising edge. The same
  // cycle uses the live value so the first beat is qualified correctly.
  assign host_req_d = host_req;
  assign wrl        = (host_req && !host_req_q) ? host_wr_n : wrl_q;
  assign wrl_d      = wrl;

  assign ref_urgent_d = |forced_vec;
  assign pend_ovf_d   = pend_ovf_q | (|sat_vec);

  always_ff @(posedge mclk) begin
    if (!s_resetn) begin
      state_q      <= ST_IDLE;
      ref_req_q    <= 1'b0;
      ref_rank_q   <= '0;
      ptr_q        <= '0;
      ref_urgent_q <= 1'b0;
      pend_ovf_q   <= 1'b0;
      wrl_q        <= 1'b0;
      host_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_req_q    <= ref_req_d;
      ref_rank_q   <= ref_rank_d;
      ptr_q        <= ptr_d;
      ref_urgent_q <= ref_urgent_d;
      pend_ovf_q   <= pend_ovf_d;
      wrl_q        <= wrl_d;
      host_req_q   <= host_req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Reset gating keeps the host enables and rank index quiet while
  // s_resetn is low, before the first reset edge has cleared the flops.
  // ---------------------------------------------------------------------------
  assign blocked = ref_urgent_q || (state_q != ST_IDLE);
  assign host_ok = s_resetn && host_req && init_done && !blocked;

  assign wen        = host_ok && !wrl;
  assign ren        = host_ok && wrl;
  assign ref_req    = ref_req_q;
  assign ref_rank   = s_resetn ? ref_rank_q : '0;
  assign ref_urgent = ref_urgent_q;
  assign pend_ovf   = pend_ovf_q;

endmodule

// File: tb/tb_refresh_sched.sv
// -----------------------------------------------------------------------------
// tb_refresh_sched
// Directed bench for refresh_sched (RANKS=2, CNT_W=12, MAX_PEND=8).
// cyc counts rising edges since the most recent reset release; outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_refresh_sched;

  localparam int RANKS    = 2;
  localparam int CNT_W    = 12;
  localparam int MAX_PEND = 8;
  localparam int PW       = 4;
  localparam int RW       = 1;

  logic             mclk = 1'b0;
  logic             s_resetn = 1'b0;
  logic             init_done = 1'b0;
  logic [CNT_W-1:0] cfg_trefi = '0;
  logic [PW-1:0]    cfg_urgent = '0;
  logic             host_req = 1'b0;
  logic             host_wr_n = 1'b1;
  logic             ref_ack = 1'b0;
  logic             trfc_done = 1'b0;
  logic             ref_req;
  logic [RW-1:0]    ref_rank;
  logic             ref_urgent;
  logic             wen;
  logic             ren;
  logic             pend_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 mclk = ~mclk;

  refresh_sched #(
    .RANKS    (RANKS),
    .CNT_W    (CNT_W),
    .MAX_PEND (MAX_PEND)
  ) u_dut (
    .mclk       (mclk),
    .s_resetn   (s_resetn),
    .init_done  (init_done),
    .cfg_trefi  (cfg_trefi),
    .cfg_urgent (cfg_urgent),
    .host_req   (host_req),
    .host_wr_n  (host_wr_n),
    .ref_ack    (ref_ack),
    .trfc_done  (trfc_done),
    .ref_req    (ref_req),
    .ref_rank   (ref_rank),
    .ref_urgent (ref_urgent),
    .wen        (wen),
    .ren        (ren),
    .pend_ovf   (pend_ovf)
  );

  task automatic step();
    @(posedge mclk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_req(input string tag, input int bound);
    int n;
    n = 0;
    while (!ref_req && n < bound) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, 32'(ref_req), 32'd1);
  endtask

  // Answer one refresh: ack after ack_dly cycles in REQ, trfc_done trfc_dly
  // cycles after the ack edge.
  task automatic service(input string tag, input logic [RW-1:0] exp_rank,
                         input int ack_dly, input int trfc_dly);
    wait_req(tag, 64);
    check({tag, "_rank"}, 32'(ref_rank), 32'(exp_rank));
    repeat (ack_dly) step();
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    check({tag, "_req_drop"}, 32'(ref_req), 32'd0);
    repeat (trfc_dly - 1) step();
    check({tag, "_rank_hold"}, 32'(ref_rank), 32'(exp_rank));
    trfc_done = 1'b1;
    step();
    trfc_done = 1'b0;
  endtask

  task automatic quiet_until(input string tag, input int until_cyc);
    logic q;
    q = 1'b1;
    while (cyc < until_cyc) begin
      step();
      if (ref_req) q = 1'b0;
    end
    check(tag, 32'(q), 32'd1);
  endtask

  task automatic release_reset();
    s_resetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // ---------------- A: reset state, host request held off ----------------
    host_req  = 1'b1;
    host_wr_n = 1'b0;
    repeat (3) step();
    check("A_ref_req",    32'(ref_req),    32'd0);
    check("A_ref_rank",   32'(ref_rank),   32'd0);
    check("A_ref_urgent", 32'(ref_urgent), 32'd0);
    check("A_pend_ovf",   32'(pend_ovf),   32'd0);
    check("A_wen",        32'(wen),        32'd0);
    check("A_ren",        32'(ren),        32'd0);
    host_req = 1'b0;

    // ---------------- B: basic refresh, both ranks, pointer ----------------
    cfg_trefi  = 12'd100;
    cfg_urgent = '0;
    init_done  = 1'b1;
    release_reset();
    repeat (100) step();
    check("B_no_req_at_tick", 32'(ref_req), 32'd0);
    step();
    check("B_req_latency", 32'(ref_req), 32'd1);
    service("B0", 1'b0, 2, 10);
    check("B0_idle_after", 32'(ref_req), 32'd0);
    step();
    check("B1_req_latency", 32'(ref_req), 32'd1);
    service("B1", 1'b1, 2, 10);
    quiet_until("B_pending_drained", 200);
    step();
    check("B_next_req", 32'(ref_req), 32'd1);
    check("B_ptr_wrap_rank", 32'(ref_rank), 32'd0);

    // ---------------- C: saturation at MAX_PEND, sticky overflow ----------------
    s_resetn = 1'b0;
    step();
    cfg_trefi = 12'd10;
    release_reset();
    repeat (89) step();
    check("C_no_ovf_at_8", 32'(pend_ovf), 32'd0);
    step();
    check("C_ovf_on_9th_tick", 32'(pend_ovf), 32'd1);
    repeat (10) step();
    check("C_ovf_sticky", 32'(pend_ovf), 32'd1);
    check("C_no_urgent_thr0", 32'(ref_urgent), 32'd0);
    cfg_trefi = 12'hFFF;
    for (int k = 0; k < 16; k++) begin
      service($sformatf("C_drain%0d", k), RW'(k % 2), 1, 3);
    end
    quiet_until("C_drained_at_8_each", cyc + 30);
    check("C_ovf_still_set", 32'(pend_ovf), 32'd1);

    // ---------------- D: reset while in WAIT ----------------
    cfg_trefi = 12'd10;
    wait_req("D_pre", 20);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    check("D_in_wait", 32'(ref_req), 32'd0);
    s_resetn = 1'b0;
    step();
    check("D_rst_ref_req",    32'(ref_req),    32'd0);
    check("D_rst_pend_ovf",   32'(pend_ovf),   32'd0);
    check("D_rst_ref_urgent", 32'(ref_urgent), 32'd0);
    check("D_rst_ref_rank",   32'(ref_rank),   32'd0);
    release_reset();
    quiet_until("D_counts_cleared", 10);
    step();
    check("D_first_req_after_rst", 32'(ref_req), 32'd1);
    check("D_first_rank", 32'(ref_rank), 32'd0);

    // ---------------- E: tick coincident with trfc_done ----------------
    // cyc 11: REQ rank 0. Ack at edge 12, trfc_done at edge 20 = tick edge.
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    while (cyc < 19) step();
    trfc_done = 1'b1;
    step();
    trfc_done = 1'b0;
    cfg_trefi = 12'hFFF;
    // rank0 owes 1 (unchanged), rank1 owes 2; pointer sits at rank 1.
    service("E0", 1'b1, 1, 3);
    service("E1", 1'b0, 1, 3);
    service("E2", 1'b1, 1, 3);
    quiet_until("E_exact_count", cyc + 30);

    // ---------------- F: forced refresh with host busy ----------------
    s_resetn = 1'b0;
    step();
    cfg_trefi  = 12'd20;
    cfg_urgent = 4'd4;
    host_wr_n  = 1'b1;
    release_reset();
    host_req = 1'b1;
    repeat (80) step();
    check("F_no_req_below_thr", 32'(ref_req),    32'd0);
    check("F_not_urgent_yet",   32'(ref_urgent), 32'd0);
    check("F_ren_before",       32'(ren),        32'd1);
    check("F_wen_before",       32'(wen),        32'd0);
    step();
    check("F_req_at_thr",  32'(ref_req),    32'd1);
    check("F_urgent_set",  32'(ref_urgent), 32'd1);
    check("F_ren_blocked", 32'(ren),        32'd0);
    service("F0", 1'b0, 0, 1);
    step();
    check("F1_req", 32'(ref_req), 32'd1);
    check("F1_ren_blocked", 32'(ren), 32'd0);
    service("F1", 1'b1, 0, 1);
    check("F_urgent_lag", 32'(ref_urgent), 32'd1);
    step();
    check("F_urgent_clear", 32'(ref_urgent), 32'd0);
    check("F_ren_resumes",  32'(ren),        32'd1);
    check("F_no_more_req",  32'(ref_req),    32'd0);
    host_req = 1'b0;
    step();
    check("F_opportunistic_req",  32'(ref_req),  32'd1);
    check("F_opportunistic_rank", 32'(ref_rank), 32'd0);

    // ---------------- G: direction latch ----------------
    s_resetn = 1'b0;
    step();
    cfg_trefi  = '0;
    cfg_urgent = '0;
    host_req   = 1'b0;
    release_reset();
    step();
    host_wr_n = 1'b0;
    host_req  = 1'b1;
    #1;
    check("G_wen_rise", 32'(wen), 32'd1);
    check("G_ren_rise", 32'(ren), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      host_wr_n = ~host_wr_n;
      #1;
      check($sformatf("G_wen_hold%0d", k), 32'(wen), 32'd1);
      check($sformatf("G_ren_hold%0d", k), 32'(ren), 32'd0);
    end
    host_req = 1'b0;
    step();
    host_wr_n = 1'b1;
    host_req  = 1'b1;
    #1;
    check("G_ren_rise", 32'(ren), 32'd1);
    check("G_wen_off",  32'(wen), 32'd0);
    step();
    host_wr_n = 1'b0;
    #1;
    check("G_ren_hold", 32'(ren), 32'd1);
    init_done = 1'b0;
    #1;
    check("G_ren_no_init", 32'(ren), 32'd0);
    check("G_wen_no_init", 32'(wen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/refresh_sched.md
REFRESH_SCHED -- requirements
Module: refresh_sched

Interface
REQ-001 The block SHALL expose parameter RANKS, default 2, number of independently refreshed ranks (1..8).
REQ-002 The block SHALL expose parameter CNT_W, default 12, width of the tREFI interval counter.
REQ-003 The block SHALL expose parameter MAX_PEND, default 8, maximum postponed refreshes per rank.
REQ-004 Ports, clock and reset first; PW = clog2(MAX_PEND+1), RW = max(1, clog2(RANKS)):
- mclk  in  1  clock
- s_resetn  in  1  reset, synchronous, active-low
- init_done  in  1  SDRAM initialisation complete
- cfg_trefi  in  CNT_W  refresh interval in mclk cycles; 0 = refresh disabled
- cfg_urgent  in  PW  pending-count threshold that forces refresh
- host_req  in  1  host read/write request
- host_wr_n  in  1  0 = write, 1 = read
- ref_ack  in  1  command sequencer accepted ref_req
- trfc_done  in  1  tRFC elapsed for the issued refresh
- ref_req  out  1  refresh request to sequencer
- ref_rank  out  RW  rank targeted by ref_req
- ref_urgent  out  1  some rank at or above cfg_urgent
- wen  out  1  qualified write enable
- ren  out  1  qualified read enable
- pend_ovf  out  1  sticky: a tick was lost at MAX_PEND

Function
REQ-005 Each rank SHALL own an interval counter: it counts 0..cfg_trefi-1, then wraps to 0 and issues a one-cycle tick.
REQ-006 On a tick, the rank's pending count SHALL increment; on trfc_done for that rank, it SHALL decrement; tick and trfc_done in the same cycle SHALL leave it unchanged.
REQ-007 A pending count at MAX_PEND SHALL saturate on a tick (no change) and set pend_ovf, which holds until reset.
REQ-008 All rank counters SHALL start in phase; skewing is out of scope.
REQ-009 When init_done=0 or cfg_trefi=0, interval counters SHALL hold at 0 and no ticks SHALL occur; pending counts SHALL hold.
REQ-010 A rank SHALL be eligible when pending>0 and host_req=0 (opportunistic), or when pending>=cfg_urgent and cfg_urgent!=0 (forced).
REQ-011 ref_urgent SHALL be registered: high when any rank's pending>=cfg_urgent and cfg_urgent!=0.
REQ-012 The FSM SHALL have states IDLE, REQ and WAIT.
- IDLE->REQ when any rank is eligible.
- REQ->WAIT on ref_ack.
- WAIT->IDLE on trfc_done.
REQ-013 Rank choice in IDLE SHALL be round-robin, starting after the last granted rank.
- Forced ranks take priority over opportunistic ones.
- The pointer advances on ref_ack.
REQ-014 ref_req SHALL be high exactly in REQ, registered, with ref_rank stable from REQ entry until WAIT exits.
REQ-015 ref_ack outside REQ and trfc_done outside WAIT SHALL be ignored.
REQ-016 A host request SHALL be blocked when ref_urgent=1 or the state is not IDLE.
REQ-017 wen SHALL equal host_req & init_done & !blocked & !wrl; ren SHALL equal host_req & init_done & !blocked & wrl.
REQ-018 wrl SHALL be host_wr_n captured on the host_req rising edge and held while host_req stays high.
REQ-019 wen and ren SHALL never be high together.
REQ-020 Latency: ref_req SHALL rise one cycle after the eligibility condition first holds in IDLE.

Reset
REQ-021 With s_resetn=0 at a mclk edge, the following SHALL clear, including mid-refresh:
- all interval and pending counts to 0
- FSM to IDLE and round-robin pointer to rank 0
- ref_req, ref_urgent, pend_ovf and wrl to 0
REQ-022 During reset, wen and ren SHALL be 0; ref_rank SHALL be 0.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding (IDLE/REQ/WAIT), the MAX_PEND default and the PW/RW width functions.
REQ-024 Per-rank interval plus pending logic SHALL be a sub-module, ref_rank_cnt, instantiated RANKS times.

Verification
REQ-025 cfg_trefi=100, host idle, ack after 2 cycles, trfc_done after 10 -> for rank 0 then rank 1 (pointer advances at ref_ack):
- ref_req 1 cycle after the tick
- ref_rank 0, then 1
- pending returns to 0
REQ-026 cfg_trefi=20, cfg_urgent=4, host_req held high -> no ref_req until pending=4, then:
- ref_urgent=1
- wen/ren forced 0
- refreshes drain until pending<4, then host traffic resumes
REQ-027 cfg_trefi=10, no acks for 100 cycles -> pending saturates at 8 and pend_ovf=1 sticky.
REQ-028 Tick coincident with trfc_done on the same rank -> pending unchanged.
REQ-029 s_resetn=0 while in WAIT -> next cycle: IDLE, ref_req=0, all counts 0, pend_ovf=0.
REQ-030 host_req rises with host_wr_n=0, then host_wr_n toggles while host_req stays high -> wen stays 1, ren stays 0.
